core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the RISC-V core datapath when instruction and data share one single-port memory bus with a req/ready handshake.
- Arbitrates the bus between instruction fetch (address = PC) and load/store (address = ALU result).
- Holds the fetched instruction in a register and gates PC update and register-file write, so each instruction retires exactly once.
- Sits between the datapath, the main decoder and the external memory bus.

---
 rtl/core_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer sharing one single-port req/ready memory bus.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] RESET_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_write_dec,
  input  logic        halt_req,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] instr_q,
  output logic        instr_valid,
  output logic [31:0] load_data,
  output logic        pc_en,
  output logic        reg_write_en,
  output logic        halted,
  output logic        bus_error,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        retire;
  logic        timeout_hit;

  // Ready on the last allowed wait cycle is checked before this flag, so it wins.
  assign timeout_hit = TO_EN && (wait_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    load_data_d   = load_data_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    pc_en         = 1'b0;
    reg_write_en  = 1'b0;
    retire        = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end

      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          retire       = 1'b1;
          reg_write_en = reg_write_dec;
        end
      end

      S_MEM: begin
        // A load+store decode collision is handled as a load.
        mem_req   = 1'b1;
        mem_addr  = alu_addr;
        mem_we    = is_store && !is_load;
        mem_wdata = store_data;
        if (mem_ready) begin
          if (is_load) begin
            load_data_d = mem_rdata;
            state_d     = S_WB;
          end else begin
            // Stores retire on the completing bus cycle itself.
            retire = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end

      S_WB: begin
        retire       = 1'b1;
        reg_write_en = reg_write_dec;
      end

      S_HALT: begin
        if (!halt_req) state_d = S_FETCH;
      end

      S_ERROR: state_d = S_ERROR;

      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      pc_en   = 1'b1;
      state_d = halt_req ? S_HALT : S_FETCH;
    end

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = 32'd0;
    end else if (mem_req && !mem_ready) begin
      wait_d = wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= 32'd0;
      instr_q       <= RESET_INSTR;
      instr_valid_q <= 1'b0;
      load_data_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      load_data_q   <= load_data_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign load_data   = load_data_q;
  assign halted      = (state_q == S_HALT);
  assign bus_error   = (state_q == S_ERROR);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  assign cycle_cnt_d   = cycle_cnt_q + 32'd1;
  assign instret_cnt_d = pc_en ? instret_cnt_q + 32'd1 : instret_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a program-level model expands each instruction into its
// expected bus/retire cycles, which are then replayed against the DUT cycle by cycle.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, alu_addr, store_data, mem_rdata;
  logic        is_load, is_store, reg_write_dec, halt_req, mem_ready;
  logic        mem_req, mem_we, pc_en, reg_write_en, halted, bus_error, instr_valid;
  logic [31:0] mem_addr, mem_wdata, instr_q, load_data, cycle_cnt, instret_cnt;

  core_seq_ctrl #(.TIMEOUT_CYCLES(4), .RESET_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .pc(pc), .alu_addr(alu_addr), .store_data(store_data),
    .is_load(is_load), .is_store(is_store), .reg_write_dec(reg_write_dec),
    .halt_req(halt_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr_q(instr_q), .instr_valid(instr_valid), .load_data(load_data),
    .pc_en(pc_en), .reg_write_en(reg_write_en), .halted(halted), .bus_error(bus_error),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {mem_req, mem_we, pc_en, reg_write_en, halted, bus_error}
  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        hreq;
    logic [31:0] sd;
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ci;
    logic [31:0] instr;
    logic        cl;
    logic [31:0] ld;
  } cyc_t;

  cyc_t        tr[$];
  logic [31:0] pcb, pc_r;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic rdy, input logic [31:0] rdata, input logic hreq,
                              input logic [5:0] ctl, input logic [31:0] addr,
                              input logic [31:0] wdata);
    cyc_t r;
    r.rdy = rdy; r.rdata = rdata; r.hreq = hreq; r.sd = wdata;
    r.ctl = ctl; r.addr = addr; r.wdata = wdata;
    r.ci = 1'b0; r.instr = 32'd0; r.cl = 1'b0; r.ld = 32'd0;
    return r;
  endfunction

  // Instruction classes by opcode; custom-0 decodes as both load and store.
  function automatic logic op_ld(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0001011);
  endfunction
  function automatic logic op_st(input logic [6:0] o);
    return (o == 7'b0100011) || (o == 7'b0001011);
  endfunction
  function automatic logic op_rw(input logic [6:0] o);
    return !((o == 7'b0100011) || (o == 7'b1100011));
  endfunction

  task automatic drive_dec();
    is_load       = op_ld(instr_q[6:0]);
    is_store      = op_st(instr_q[6:0]);
    reg_write_dec = op_rw(instr_q[6:0]);
    alu_addr      = {20'h0, instr_q[31:20]};
  endtask

  task automatic add_idle();
    tr.push_back(mk(rbit(), $urandom, rbit(), 6'b000000, 32'd0, $urandom));
  endtask

  // Expand one instruction (fetch waits fw, memory waits mw, optional halt of hold cycles).
  task automatic add_ins(input logic [31:0] ins, input int fw, input int mw,
                         input logic hlt, input int hold, input logic [31:0] dat);
    cyc_t        r;
    logic        isl, iss, rwd;
    logic [31:0] aa;
    isl = op_ld(ins[6:0]);
    iss = op_st(ins[6:0]) && !isl;
    rwd = op_rw(ins[6:0]);
    aa  = {20'h0, ins[31:20]};
    for (int k = 0; k < fw; k++) tr.push_back(mk(1'b0, $urandom, rbit(), 6'b100000, pcb, $urandom));
    tr.push_back(mk(1'b1, ins, rbit(), 6'b100000, pcb, $urandom));
    if (!isl && !iss) begin
      r = mk(rbit(), $urandom, hlt, {2'b00, 1'b1, rwd, 2'b00}, 32'd0, $urandom);
      r.ci = 1'b1; r.instr = ins;
      tr.push_back(r);
    end else begin
      r = mk(rbit(), $urandom, rbit(), 6'b000000, 32'd0, $urandom);
      r.ci = 1'b1; r.instr = ins;
      tr.push_back(r);
      for (int k = 0; k < mw; k++) tr.push_back(mk(1'b0, $urandom, rbit(), {1'b1, iss, 4'b0000}, aa, dat));
      if (isl) begin
        tr.push_back(mk(1'b1, dat, rbit(), 6'b100000, aa, $urandom));
        r = mk(rbit(), $urandom, hlt, {2'b00, 1'b1, rwd, 2'b00}, 32'd0, $urandom);
        r.cl = 1'b1; r.ld = dat;
        tr.push_back(r);
      end else begin
        tr.push_back(mk(1'b1, $urandom, hlt, 6'b111000, aa, dat));
      end
    end
    pcb += 32'd4;
    if (hlt) begin
      for (int k = 0; k < hold; k++) tr.push_back(mk(rbit(), $urandom, 1'b1, 6'b000010, 32'd0, $urandom));
      tr.push_back(mk(rbit(), $urandom, 1'b0, 6'b000010, 32'd0, $urandom));
    end
  endtask

  task automatic run_trace();
    foreach (tr[i]) begin
      @(negedge clk);
      reset      = 1'b0;
      mem_ready  = tr[i].rdy;
      mem_rdata  = tr[i].rdata;
      halt_req   = tr[i].hreq;
      store_data = tr[i].sd;
      pc         = pc_r;
      drive_dec();
      #1;
      cyc++;
      chk("ctl", 32'({mem_req, mem_we, pc_en, reg_write_en, halted, bus_error}), 32'(tr[i].ctl));
      if (tr[i].ctl[5]) chk("addr", mem_addr, tr[i].addr);
      if (tr[i].ctl[4]) chk("wdata", mem_wdata, tr[i].wdata);
      if (tr[i].ci) begin
        chk("instr", instr_q, tr[i].instr);
        chk("ivalid", 32'(instr_valid), 32'd1);
      end
      if (tr[i].cl) chk("ldata", load_data, tr[i].ld);
      if (tr[i].ctl[3]) pc_r += 32'd4;
    end
    tr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    halt_req  = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ctl", 32'({mem_req, mem_we, pc_en, reg_write_en, halted, bus_error}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_instr", instr_q, 32'h00000013);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_cyc", cycle_cnt, 32'd0);
    chk("rst_iret", instret_cnt, 32'd0);
    pcb  = 32'd0;
    pc_r = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rv, ins;
    logic [6:0]  opc;
    reset = 1'b1; pc = 32'd0; alu_addr = 32'd0; store_data = 32'd0;
    is_load = 1'b0; is_store = 1'b0; reg_write_dec = 1'b0;
    halt_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;

    // Single ALU instruction with zero-wait fetch: retire in cycle 2 after IDLE.
    do_reset();
    add_idle();
    add_ins(32'h00500093, 0, 0, 1'b0, 0, 32'd0);
    run_trace();

    // Directed load / store / halt / load+store collision / last-cycle-ready fetch.
    do_reset();
    add_idle();
    add_ins(32'h10002083, 0, 3, 1'b0, 0, 32'hDEADBEEF);
    add_ins(32'h10402023, 1, 2, 1'b0, 0, 32'h12345678);
    add_ins(32'h00100113, 0, 0, 1'b1, 3, 32'd0);
    add_ins(32'h0200000B, 0, 1, 1'b0, 0, 32'hCAFEF00D);
    add_ins(32'h00000063, 3, 0, 1'b0, 0, 32'd0);
    add_ins(32'h20002183, 2, 0, 1'b1, 0, 32'h0BADF00D);
    add_ins(32'h00200213, 0, 0, 1'b0, 0, 32'd0);
    run_trace();

    // Reset in the middle of a pending fetch drops mem_req on the next cycle.
    do_reset();
    add_idle();
    tr.push_back(mk(1'b0, $urandom, 1'b0, 6'b100000, 32'd0, $urandom));
    tr.push_back(mk(1'b0, $urandom, 1'b0, 6'b100000, 32'd0, $urandom));
    run_trace();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);

    // Fetch timeout: four unanswered request cycles, then sticky ERROR until reset.
    do_reset();
    add_idle();
    for (int k = 0; k < 4; k++) tr.push_back(mk(1'b0, $urandom, rbit(), 6'b100000, 32'd0, $urandom));
    for (int k = 0; k < 5; k++) tr.push_back(mk(rbit(), $urandom, rbit(), 6'b000001, 32'd0, $urandom));
    run_trace();

    // Three back-to-back ALU instructions with zero-wait memory.
    do_reset();
    add_idle();
    for (int k = 0; k < 3; k++) add_ins(32'h00108093, 0, 0, 1'b0, 0, 32'd0);
    run_trace();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
`ifdef SEQ_PERF_CNT_EN
    chk("perf_cyc", cycle_cnt, 32'd7);
    chk("perf_iret", instret_cnt, 32'd3);
`else
    chk("perf_cyc", cycle_cnt, 32'd0);
    chk("perf_iret", instret_cnt, 32'd0);
`endif

    // Random program against the instruction-level model.
    do_reset();
    add_idle();
    for (int n = 0; n < 40; n++) begin
      rv = $urandom;
      case ($urandom_range(0, 4))
        0:       opc = 7'b0010011;
        1:       opc = 7'b1100011;
        2:       opc = 7'b0000011;
        3:       opc = 7'b0100011;
        default: opc = 7'b0001011;
      endcase
      ins = {rv[31:7], opc};
      add_ins(ins, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
              $urandom_range(0, 3), $urandom);
    end
    run_trace();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
